// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one uart_tx serializer between NUM_REQ byte
// sources. A granted byte is presented on tx_data with a one-cycle tx_valid
// pulse, then the arbiter stays busy for a full frame plus a guard gap so the
// serializer never sees a new start pulse while it is still shifting.
module uart_tx_arbiter #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int DATA_BIT   = 8,
  parameter int STOP_BIT   = 1,
  parameter int CHECK_BIT  = 0,
  parameter int NUM_REQ    = 4,
  parameter int GAP_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  output logic [2:0]           grant_id,
  output logic                 busy
);

  // Frame timing mirrors the serializer's own baud divider, so the arbiter
  // knows when the line is free without any done/busy feedback.
  localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE;
  localparam int FRAME_CYCLES = BAUD_CNT_MAX * (1 + DATA_BIT + CHECK_BIT + STOP_BIT);
  localparam int HOLD         = FRAME_CYCLES + GAP_CYCLES;
  localparam logic [23:0] HOLD_LAST = 24'(HOLD - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]  state;
  logic [23:0] wait_cnt;
  logic [2:0]  last_grant;

  logic        win_found;
  logic [2:0]  win_idx;
  logic [7:0]  win_byte;

  // Pick the first pending requester after last_grant, wrapping around.
  always_comb begin
    // NOTE: every variable gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch to hold the old value.
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!win_found && req_valid[(int'(last_grant) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = 3'((int'(last_grant) + k) % NUM_REQ);
      end
    end
  end

  assign win_byte = req_data[int'(win_idx)*8 +: 8];

  // Frame in progress whenever we are past the grant decision.
  assign busy = (state != ST_IDLE);

  // Scheduler state machine: grant in IDLE, pulse in SEND, hold off in WAIT.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments throughout, so every register samples the
    // pre-edge values and ordering of statements inside the block is irrelevant.
    if (rst) begin
      state      <= ST_IDLE;
      wait_cnt   <= '0;
      last_grant <= 3'(NUM_REQ - 1);
      req_ready  <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= '0;
      grant_id   <= '0;
    end else begin
      // Accept and start pulses last exactly one cycle.
      req_ready <= '0;
      tx_valid  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            state      <= ST_SEND;
            tx_data    <= win_byte;
            grant_id   <= win_idx;
            last_grant <= win_idx;
            req_ready  <= NUM_REQ'(1) << win_idx;
            tx_valid   <= 1'b1;
          end
        end
        ST_SEND: begin
          state    <= ST_WAIT;
          wait_cnt <= '0;
        end
        ST_WAIT: begin
          if (wait_cnt == HOLD_LAST) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 24'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a table of single-grant vectors
// run from reset, plus hand-written sequences for frame length, continuous
// round-robin, fairness, reset during WAIT and the parity frame length.
module tb_uart_tx_arbiter;

  localparam int NUM_REQ = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main instance: HOLD = 102.
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data  = {8'hD3, 8'hA5, 8'h5C, 8'h3E};
  logic [NUM_REQ-1:0]   req_ready;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic [2:0]           grant_id;
  logic                 busy;

  uart_tx_arbiter #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BIT(8), .STOP_BIT(1),
    .CHECK_BIT(0), .NUM_REQ(NUM_REQ), .GAP_CYCLES(2)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .grant_id(grant_id), .busy(busy)
  );

  // Parity instance: HOLD = 112.
  logic [NUM_REQ-1:0]   p_req_valid = '0;
  logic [8*NUM_REQ-1:0] p_req_data  = '0;
  logic [NUM_REQ-1:0]   p_req_ready;
  logic [7:0]           p_tx_data;
  logic                 p_tx_valid;
  logic [2:0]           p_grant_id;
  logic                 p_busy;

  uart_tx_arbiter #(
    .CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .DATA_BIT(8), .STOP_BIT(1),
    .CHECK_BIT(1), .NUM_REQ(NUM_REQ), .GAP_CYCLES(2)
  ) dut_par (
    .clk(clk), .rst(rst), .req_valid(p_req_valid), .req_data(p_req_data),
    .req_ready(p_req_ready), .tx_data(p_tx_data), .tx_valid(p_tx_valid),
    .grant_id(p_grant_id), .busy(p_busy)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] rv;
    logic [3:0] exp_ready;
    logic [2:0] exp_grant;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Advance one cycle and sample 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req_valid = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      tick();
      n++;
    end
    check("wait_idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_tx(input bit par, output int t);
    int n = 0;
    while (!(par ? p_tx_valid : tx_valid) && n < 400) begin
      tick();
      n++;
    end
    check("wait_tx_timeout", {31'd0, (par ? p_tx_valid : tx_valid)}, 32'd1);
    t = cyc;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ready"}, {28'd0, req_ready}, 32'd0);
    check({name, "_txv"},   {31'd0, tx_valid},  32'd0);
    check({name, "_data"},  {24'd0, tx_data},   32'd0);
    check({name, "_gid"},   {29'd0, grant_id},  32'd0);
    check({name, "_busy"},  {31'd0, busy},      32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t[5];
    int g[5];
    int t1, t2, n;
    bit stable;

    // Starting from last_grant = 3; req bytes: 0:3E 1:5C 2:A5 3:D3.
    vecs[0] = '{4'b0100, 4'b0100, 3'd2, 8'hA5};
    vecs[1] = '{4'b1111, 4'b1000, 3'd3, 8'hD3};
    vecs[2] = '{4'b1111, 4'b0001, 3'd0, 8'h3E};
    vecs[3] = '{4'b0110, 4'b0010, 3'd1, 8'h5C};
    vecs[4] = '{4'b1001, 4'b1000, 3'd3, 8'hD3};
    vecs[5] = '{4'b0001, 4'b0001, 3'd0, 8'h3E};
    vecs[6] = '{4'b1000, 4'b1000, 3'd3, 8'hD3};
    vecs[7] = '{4'b0011, 4'b0001, 3'd0, 8'h3E};
    vecs[8] = '{4'b1010, 4'b0010, 3'd1, 8'h5C};

    // Reset held with every requester pending: nothing may be accepted.
    rst = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle_outputs("reset");
      if (i == 2) begin
        req_valid = '0;
        rst = 1'b0;
      end
    end
    tick();
    check_idle_outputs("post_reset");

    // Single request: latency 1, busy for 103 cycles, tx_data held.
    req_valid = 4'b0100;
    tick();
    check("single_txv",   {31'd0, tx_valid},  32'd1);
    check("single_ready", {28'd0, req_ready}, 32'b0100);
    check("single_data",  {24'd0, tx_data},   32'hA5);
    check("single_gid",   {29'd0, grant_id},  32'd2);
    req_valid = '0;
    n = 0;
    stable = 1'b1;
    while (busy && n < 400) begin
      if (tx_data != 8'hA5) stable = 1'b0;
      n++;
      tick();
    end
    check("single_busy_len", n, 32'd103);
    check("single_data_stable", {31'd0, stable}, 32'd1);
    check("single_data_after", {24'd0, tx_data}, 32'hA5);

    // Table of grants from a fresh pointer.
    do_reset();
    for (int i = 0; i < 9; i++) begin
      wait_idle();
      req_valid = vecs[i].rv;
      tick();
      check($sformatf("vec%0d_ready", i), {28'd0, req_ready}, {28'd0, vecs[i].exp_ready});
      check($sformatf("vec%0d_txv", i),   {31'd0, tx_valid},  32'd1);
      check($sformatf("vec%0d_gid", i),   {29'd0, grant_id},  {29'd0, vecs[i].exp_grant});
      check($sformatf("vec%0d_data", i),  {24'd0, tx_data},   {24'd0, vecs[i].exp_data});
      check($sformatf("vec%0d_busy", i),  {31'd0, busy},      32'd1);
      req_valid = '0;
      tick();
      check($sformatf("vec%0d_pulse_end", i), {27'd0, req_ready, tx_valid}, 32'd0);
    end
    wait_idle();

    // All four requesting continuously: order 0,1,2,3,0 every 104 cycles.
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_tx(1'b0, t[i]);
      g[i] = int'(grant_id);
      check($sformatf("rr%0d_ready", i), {28'd0, req_ready}, 32'd1 << g[i]);
      tick();
      check($sformatf("rr%0d_one_cycle", i), {27'd0, req_ready, tx_valid}, 32'd0);
    end
    check("rr_order0", g[0], 32'd0);
    check("rr_order1", g[1], 32'd1);
    check("rr_order2", g[2], 32'd2);
    check("rr_order3", g[3], 32'd3);
    check("rr_order4", g[4], 32'd0);
    for (int i = 1; i < 5; i++)
      check($sformatf("rr_spacing%0d", i), t[i] - t[i-1], 32'd104);
    req_valid = '0;
    wait_idle();

    // Fairness: 0 and 3 pending, 0 keeps requesting -> 0,3,0.
    do_reset();
    req_valid = 4'b1001;
    for (int i = 0; i < 3; i++) begin
      wait_tx(1'b0, t[i]);
      g[i] = int'(grant_id);
      tick();
    end
    check("fair0", g[0], 32'd0);
    check("fair1", g[1], 32'd3);
    check("fair2", g[2], 32'd0);
    req_valid = '0;
    wait_idle();

    // Reset at WAIT count 50 with requester 1 held.
    do_reset();
    req_valid = 4'b0010;
    wait_tx(1'b0, t1);
    check("rw_gid_before", {29'd0, grant_id}, 32'd1);
    repeat (51) tick();
    check("rw_busy_before", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    check_idle_outputs("rw_reset");
    rst = 1'b0;
    tick();
    check("rw_regrant_ready", {28'd0, req_ready}, 32'b0010);
    check("rw_regrant_txv",   {31'd0, tx_valid},  32'd1);
    check("rw_regrant_gid",   {29'd0, grant_id},  32'd1);
    req_valid = '0;
    wait_idle();

    // Parity frame: back-to-back 0x00 then 0xFF from requester 1, 114 apart.
    p_req_data = '0;
    p_req_valid = 4'b0010;
    wait_tx(1'b1, t1);
    check("par_first_data", {24'd0, p_tx_data},  32'h00);
    check("par_first_gid",  {29'd0, p_grant_id}, 32'd1);
    tick();
    p_req_data[15:8] = 8'hFF;
    wait_tx(1'b1, t2);
    check("par_second_data", {24'd0, p_tx_data}, 32'hFF);
    check("par_spacing", t2 - t1, 32'd114);
    p_req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin scheduler that shares one `uart_tx` serializer between NUM_REQ byte sources. It accepts one byte at a time from a winning requester and issues a single-cycle `tx_valid` pulse to the serializer. It holds `tx_data` stable for the whole frame and blocks further grants until the frame plus a guard gap has elapsed. The frame length is derived from the same UART parameters the serializer uses, so no busy/done feedback from the serializer is needed.

## Interface
- CLK_FREQ, 'd100_000_000, system clock in Hz; must equal serializer setting
- BAUD_RATE, 'd9600, bit rate; must equal serializer setting
- DATA_BIT, 'd8, data bits per frame (1..8)
- STOP_BIT, 'd1, stop bits per frame (1..2)
- CHECK_BIT, 'd0, parity bits per frame (0 or 1)
- NUM_REQ, 'd4, number of requesters (2..8)
- GAP_CYCLES, 'd2, idle guard cycles after each frame (>=1)
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- req_valid  input  NUM_REQ  bit i: requester i has a byte pending; held until accepted
- req_data  input  8*NUM_REQ  byte of requester i on bits [8i+7:8i]; stable while req_valid[i]
- req_ready  output  NUM_REQ  one-hot, one-cycle accept pulse to the granted requester
- tx_data  output  8  byte to serializer; held for the entire frame
- tx_valid  output  1  one-cycle start pulse to serializer
- grant_id  output  3  index of the most recently granted requester
- busy  output  1  high while a frame is being scheduled or sent

## Operation
- Derived constants:
  - BAUD_CNT_MAX = CLK_FREQ/BAUD_RATE (integer divide)
  - FRAME_CYCLES = BAUD_CNT_MAX*(1+DATA_BIT+CHECK_BIT+STOP_BIT)
  - HOLD = FRAME_CYCLES+GAP_CYCLES
- Wait counter is 24 bits; HOLD must be < 2^24.
- States:
  - IDLE: if any req_valid, select a winner, latch its byte, go to SEND.
  - SEND: one cycle. Always go to WAIT.
  - WAIT: count 0..HOLD-1. At HOLD-1 go to IDLE.
- Round-robin arbitration:
  - Pointer last_grant resets to NUM_REQ-1.
  - Search order starts at last_grant+1 mod NUM_REQ and wraps.
  - First set req_valid bit wins; last_grant updates to the winner.
- On the IDLE->SEND edge, register in the same edge:
  - tx_data <= winner byte
  - grant_id <= winner
  - req_ready[winner] <= 1
  - tx_valid <= 1
- On leaving SEND: req_ready and tx_valid clear to 0.
- tx_data and grant_id hold their values until the next grant.
- req_valid is not sampled in SEND or WAIT. Requests arriving then wait in the requester.
- busy = 1 in SEND and WAIT; 0 in IDLE.
- Reset values (all outputs): req_ready=0, tx_valid=0, tx_data=0, grant_id=0, busy=0; state IDLE, counter 0, last_grant=NUM_REQ-1.

## Timing
- Request visible in IDLE at cycle N produces req_ready/tx_valid/busy high at cycle N+1: latency 1.
- WAIT occupies cycles N+2..N+1+HOLD.
- IDLE resumes at N+2+HOLD.
- Earliest next tx_valid is at N+3+HOLD; minimum pulse spacing is HOLD+2 cycles.
- Requester handshake:
  - Requester may drop or change req_valid/req_data from cycle N+2.
  - A requester keeping req_valid high after its req_ready is treated as a new request.
- Simultaneous requests: exactly one is granted per frame; the others stay pending without loss.
- Pointer wrap: after a grant to NUM_REQ-1, the search starts at 0.
- Reset mid-operation:
  - rst is sampled high at an edge: on that edge all state and outputs go to reset values.
  - A byte already accepted is dropped; the shared reset also aborts the serializer.
  - After rst deasserts, a pending request is granted at the second edge: one edge in IDLE, then SEND.
- Reset asserted in IDLE while requests are pending: no req_ready is issued.

## Test plan
Sim parameters: CLK_FREQ=1_000_000, BAUD_RATE=100_000, GAP_CYCLES=2, NUM_REQ=4; BAUD_CNT_MAX=10, FRAME_CYCLES=100, HOLD=102 unless stated.

- Reset: hold rst 3 cycles with all req_valid=1 -> during and one cycle after reset, all outputs 0 and no req_ready pulse.
- Single request: req_valid[2]=1, data 0xA5 in IDLE at cycle N:
  - cycle N+1: tx_valid=1, req_ready=4'b0100, tx_data=0xA5, grant_id=2.
  - busy high N+1..N+103; tx_data stays 0xA5 throughout.
  - Attached `uart_tx` line decodes LSB-first 0xA5 with one start and one stop bit.
- All four requesting continuously -> grant order 0,1,2,3,0; tx_valid pulses exactly 104 cycles apart; each req_ready one-hot for one cycle.
- Fairness: req 0 and req 3 both pending, req 0 re-asserts right after its grant -> next grant goes to 3, then 0.
- Reset mid-WAIT: assert rst at WAIT count 50 with req_valid[1] held -> next cycle busy=0, tx_valid=0, grant_id=0. After release, requester 1 is granted (req_ready[1]=1) at the second edge.
- Parity config: CHECK_BIT=1 (FRAME_CYCLES=110, HOLD=112), back-to-back bytes 0x00 and 0xFF from req 1 -> tx_valid spacing 114 cycles; both frames decode correctly with parity.
